// File: rtl/shiftery_pipe_if.sv
// Handshake/data bundle for shiftery_pipe: sample input side and result output side.
// master = the environment driving samples and consuming results, slave = the shifter.
interface shiftery_pipe_if #(
    parameter int IN_W  = 20,
    parameter int EXP_W = 5,
    parameter int OUT_W = 23
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  y_f;
    logic [EXP_W-1:0] exp_ff;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] ff;
    logic             out_range;

    modport master (
        output in_valid,
        output y_f,
        output exp_ff,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  ff,
        input  out_range
    );

    modport slave (
        input  in_valid,
        input  y_f,
        input  exp_ff,
        input  out_ready,
        output in_ready,
        output out_valid,
        output ff,
        output out_range
    );
endinterface

// File: rtl/shiftery_pipe.sv
// Pipelined exponent-driven barrel shifter: ff = y_f * 2^exp_ff with valid/ready flow control.
// Build option ROUNDING_RSHIFT_EN: right shifts round half-up instead of truncating.
module shiftery_pipe #(
    parameter int IN_W       = 20,
    parameter int EXP_W      = 5,
    parameter int MAX_LSHIFT = 3,
    parameter int MAX_RSHIFT = 12,
    parameter int OUT_W      = 23
) (
    input logic            clk,
    input logic            rst_n,
    shiftery_pipe_if.slave bus
);

    localparam int MAX_SH = (MAX_LSHIFT > MAX_RSHIFT) ? MAX_LSHIFT : MAX_RSHIFT;
    localparam int AMT_RAW = $clog2(MAX_SH + 1);
    localparam int AMT_W = (AMT_RAW < 2) ? 2 : AMT_RAW;
`ifdef ROUNDING_RSHIFT_EN
    localparam int GB = 1;
`else
    localparam int GB = 0;
`endif
    // One guard bit below the binary point carries y_f[n-1] out of a right shift.
    localparam int XW = OUT_W + GB;

    if (OUT_W < IN_W + MAX_LSHIFT) begin : g_width_check
        $error("shiftery_pipe: OUT_W must be >= IN_W + MAX_LSHIFT");
    end

    logic             stall;

    logic             s0_valid_q, s0_valid_d;
    logic [IN_W-1:0]  s0_y_q, s0_y_d;
    logic             s0_left_q, s0_left_d;
    logic [AMT_W-1:0] s0_amt_q, s0_amt_d;
    logic             s0_rng_q, s0_rng_d;

    logic             s1_valid_q, s1_valid_d;
    logic [XW-1:0]    s1_x_q, s1_x_d;
    logic             s1_left_q, s1_left_d;
    logic [1:0]       s1_amt_q, s1_amt_d;
    logic             s1_rng_q, s1_rng_d;

    logic             s2_valid_q, s2_valid_d;
    logic [XW-1:0]    s2_x_q, s2_x_d;
    logic             s2_rng_q, s2_rng_d;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] ff_q, ff_d;
    logic             out_range_q, out_range_d;

    int               exp_s;
    logic             dec_rng;
    logic             dec_left;
    logic [AMT_W-1:0] dec_amt;
    logic [AMT_W-1:0] coarse_amt;
    logic [XW-1:0]    s0_x;
    logic [OUT_W-1:0] result;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    always_comb begin
        exp_s    = int'($signed(bus.exp_ff));
        dec_rng  = (exp_s > MAX_LSHIFT) || (exp_s < -MAX_RSHIFT);
        dec_left = dec_rng || (exp_s >= 0);
        dec_amt  = '0;
        if (!dec_rng) begin
            dec_amt = (exp_s >= 0) ? AMT_W'(exp_s) : AMT_W'(-exp_s);
        end
    end

    always_comb begin
        s0_x       = XW'(s0_y_q) << GB;
        coarse_amt = s0_amt_q & ~AMT_W'(3);
        result     = OUT_W'(s2_x_q >> GB);
`ifdef ROUNDING_RSHIFT_EN
        // Guard bit is zero for left and out-of-range cases, so only right shifts round.
        result     = OUT_W'(s2_x_q >> GB) + OUT_W'(s2_x_q[0]);
`endif
    end

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_y_d      = s0_y_q;
        s0_left_d   = s0_left_q;
        s0_amt_d    = s0_amt_q;
        s0_rng_d    = s0_rng_q;
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_left_d   = s1_left_q;
        s1_amt_d    = s1_amt_q;
        s1_rng_d    = s1_rng_q;
        s2_valid_d  = s2_valid_q;
        s2_x_d      = s2_x_q;
        s2_rng_d    = s2_rng_q;
        out_valid_d = out_valid_q;
        ff_d        = ff_q;
        out_range_d = out_range_q;

        if (!stall) begin
            s0_valid_d  = bus.in_valid;
            s0_y_d      = bus.y_f;
            s0_left_d   = dec_left;
            s0_amt_d    = dec_amt;
            s0_rng_d    = dec_rng;

            s1_valid_d  = s0_valid_q;
            s1_x_d      = s0_left_q ? (s0_x << coarse_amt) : (s0_x >> coarse_amt);
            s1_left_d   = s0_left_q;
            s1_amt_d    = s0_amt_q[1:0];
            s1_rng_d    = s0_rng_q;

            s2_valid_d  = s1_valid_q;
            s2_x_d      = s1_left_q ? (s1_x_q << s1_amt_q) : (s1_x_q >> s1_amt_q);
            s2_rng_d    = s1_rng_q;

            // Registered after the fine shift so the rounding adder gets its own cycle.
            out_valid_d = s2_valid_q;
            ff_d        = result;
            out_range_d = s2_rng_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            s0_y_q      <= '0;
            s0_left_q   <= 1'b0;
            s0_amt_q    <= '0;
            s0_rng_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_left_q   <= 1'b0;
            s1_amt_q    <= '0;
            s1_rng_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_x_q      <= '0;
            s2_rng_q    <= 1'b0;
            out_valid_q <= 1'b0;
            ff_q        <= '0;
            out_range_q <= 1'b0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_y_q      <= s0_y_d;
            s0_left_q   <= s0_left_d;
            s0_amt_q    <= s0_amt_d;
            s0_rng_q    <= s0_rng_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_left_q   <= s1_left_d;
            s1_amt_q    <= s1_amt_d;
            s1_rng_q    <= s1_rng_d;
            s2_valid_q  <= s2_valid_d;
            s2_x_q      <= s2_x_d;
            s2_rng_q    <= s2_rng_d;
            out_valid_q <= out_valid_d;
            ff_q        <= ff_d;
            out_range_q <= out_range_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ff        = ff_q;
    assign bus.out_range = out_range_q;

endmodule
